power_event_gen: RTL and testbench
==================================

POWER_EVENT_GEN -- requirements
Module: power_event_gen

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 power_state  input  2  current power FSM state: 00 SHUTDOWN, 01 DEEPSLEEP, 10 SLEEP, 11 ACTIVE.
REQ-005 conn_interval  input  16  sleep interval in clk cycles; 0 disables the timer.
REQ-006 idle_threshold  input  8  consecutive not-busy cycles that qualify as idle; 0 is treated as 1.
REQ-007 ext_wake  input  1  external wake request, synchronous to clk, level.
REQ-008 shutdown_req  input  1  host shutdown request, level.
REQ-009 cpu_busy  input  1  CPU activity, level.
REQ-010 radio_busy  input  1  radio activity, level.
REQ-011 wakeup_event  output  1  one-cycle wake pulse to the power FSM.
REQ-012 radio_request  output  1  one-cycle radio request pulse.
REQ-013 radio_idle  output  1  one-cycle radio-done pulse.
REQ-014 cpu_idle  output  1  CPU idle level.
REQ-015 timer_expired  output  1  one-cycle interval expiry pulse.
REQ-016 shutdown_cmd  output  1  one-cycle shutdown pulse.
REQ-017 timer_count  output  16  remaining interval count.

Function
REQ-018 All outputs SHALL be registered; every pulse output SHALL be high for exactly one cycle.
REQ-019 Interval timer: on the cycle power_state changes from ACTIVE to SLEEP or DEEPSLEEP, timer_count SHALL load conn_interval.
REQ-020 While power_state is SLEEP or DEEPSLEEP and timer_count > 0, timer_count SHALL decrement by 1 per cycle; at 0 it SHALL hold.
REQ-021 timer_expired and wakeup_event SHALL pulse in the cycle timer_count goes from 1 to 0.
REQ-022 conn_interval = 0 SHALL produce no expiry.
REQ-023 power_state becoming ACTIVE or SHUTDOWN SHALL clear timer_count to 0 with no expiry pulse.
REQ-024 A rising edge of ext_wake while power_state != ACTIVE SHALL pulse wakeup_event one cycle later.
REQ-025 ext_wake edge and timer expiry in the same cycle SHALL produce a single wakeup_event pulse; timer_expired still pulses.
REQ-026 The cycle after power_state enters ACTIVE from any other state, radio_request SHALL pulse once; this arms the radio idle monitor.
REQ-027 Armed monitor: count consecutive radio_busy = 0 cycles while ACTIVE; when the count reaches idle_threshold, pulse radio_idle once and disarm; radio_busy = 1 resets the count.
REQ-028 cpu_idle SHALL be high while power_state is ACTIVE and cpu_busy has been 0 for at least idle_threshold consecutive cycles; the 8-bit counter saturates at 255; cpu_busy = 1 or leaving ACTIVE SHALL clear it next cycle.
REQ-029 A rising edge of shutdown_req SHALL pulse shutdown_cmd one cycle later and clear timer_count.
REQ-030 In a cycle where shutdown_cmd pulses, wakeup_event, timer_expired and radio_request SHALL be suppressed.

Reset
REQ-031 With reset high at a clock edge, all outputs SHALL go to 0, the timer SHALL be 0, idle counters SHALL be 0, the radio monitor SHALL be disarmed and the edge detectors SHALL capture the current input levels.
REQ-032 Reset mid-count SHALL abort the count with no pulses; counting resumes only on the next ACTIVE-to-sleep transition.

Configuration
REQ-033 With WAKE_DEBOUNCE_EN defined, ext_wake SHALL be accepted only after it has been high for 4 consecutive cycles, with wakeup_event pulsing the cycle after the 4th.
REQ-034 Without WAKE_DEBOUNCE_EN, a single-cycle rise SHALL be accepted per REQ-024.

Verification
REQ-035 reset 2 cycles, power_state 11->10, conn_interval=5 -> timer_count 5,4,3,2,1,0; timer_expired and wakeup_event pulse once at the 1->0 cycle.
REQ-036 power_state 10, timer_count=3, power_state->11 -> timer_count=0, no timer_expired; radio_request pulses the next cycle.
REQ-037 ACTIVE, radio_request issued, idle_threshold=4, radio_busy 1 for 3 cycles then 0 -> radio_idle pulses once on the 4th idle cycle, not again.
REQ-038 shutdown_req rise in the same cycle as timer 1->0 -> shutdown_cmd pulses, wakeup_event and timer_expired stay 0.
REQ-039 DEEPSLEEP, ext_wake high 2 cycles -> wakeup_event pulses without WAKE_DEBOUNCE_EN; no pulse with it; with it, high 4 cycles -> one pulse.

Source files
------------

// File: rtl/power_event_gen.sv
// Power event generator: sleep interval timer, wake/shutdown pulses, radio and CPU idle monitors.
// Define WAKE_DEBOUNCE_EN to require ext_wake high for 4 consecutive cycles before it is accepted.
module power_event_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  power_state,
  input  logic [15:0] conn_interval,
  input  logic [7:0]  idle_threshold,
  input  logic        ext_wake,
  input  logic        shutdown_req,
  input  logic        cpu_busy,
  input  logic        radio_busy,
  output logic        wakeup_event,
  output logic        radio_request,
  output logic        radio_idle,
  output logic        cpu_idle,
  output logic        timer_expired,
  output logic        shutdown_cmd,
  output logic [15:0] timer_count
);

  localparam int unsigned TW  = 16;
  localparam int unsigned CW  = 8;
  localparam int unsigned DBW = 3;

  localparam logic [1:0] PS_DEEPSLEEP = 2'b01;
  localparam logic [1:0] PS_SLEEP     = 2'b10;
  localparam logic [1:0] PS_ACTIVE    = 2'b11;

  logic [1:0]    prev_state;
  logic          shut_prev;
  logic          armed;
  logic [CW-1:0] radio_cnt;
  logic [CW-1:0] cpu_cnt;

  logic          is_sleep;
  logic          is_active;
  logic          shut_rise;
  logic          load_c;
  logic          expire_c;
  logic          enter_active;
  logic          wake_accept;
  logic [CW-1:0] thr;
  logic [CW-1:0] radio_inc;
  logic [CW-1:0] cpu_cnt_next;
  logic [TW-1:0] timer_next;

`ifdef WAKE_DEBOUNCE_EN
  logic [DBW-1:0] deb_cnt;
  logic [DBW-1:0] deb_next;

  // Count consecutive high cycles, saturating at 4; accept on the 3->4 step only.
  always_comb begin
    deb_next    = '0;
    wake_accept = 1'b0;
    if (ext_wake) begin
      deb_next    = (deb_cnt == DBW'(4)) ? deb_cnt : deb_cnt + DBW'(1);
      wake_accept = (deb_cnt == DBW'(3)) && !is_active;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) deb_cnt <= ext_wake ? DBW'(4) : '0;
    else       deb_cnt <= deb_next;
  end
`else
  logic wake_prev;

  always_comb begin
    wake_accept = ext_wake && !wake_prev && !is_active;
  end

  always_ff @(posedge clk) begin
    wake_prev <= ext_wake;
  end
`endif

  // Event decode from current inputs against last-cycle levels.
  always_comb begin
    is_sleep     = (power_state == PS_SLEEP) || (power_state == PS_DEEPSLEEP);
    is_active    = (power_state == PS_ACTIVE);
    shut_rise    = shutdown_req && !shut_prev;
    load_c       = is_sleep && (prev_state == PS_ACTIVE);
    expire_c     = is_sleep && !load_c && (timer_count == TW'(1));
    enter_active = is_active && (prev_state != PS_ACTIVE);
    thr          = (idle_threshold == '0) ? CW'(1) : idle_threshold;
    radio_inc    = radio_cnt + CW'(1);
    cpu_cnt_next = '0;
    if (is_active && !cpu_busy)
      cpu_cnt_next = (cpu_cnt == '1) ? cpu_cnt : cpu_cnt + CW'(1);
    timer_next = '0;
    if (!shut_rise && is_sleep) begin
      if (load_c)                 timer_next = conn_interval;
      else if (timer_count != '0) timer_next = timer_count - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wakeup_event  <= 1'b0;
      radio_request <= 1'b0;
      radio_idle    <= 1'b0;
      cpu_idle      <= 1'b0;
      timer_expired <= 1'b0;
      shutdown_cmd  <= 1'b0;
      timer_count   <= '0;
      prev_state    <= power_state;
      shut_prev     <= shutdown_req;
      armed         <= 1'b0;
      radio_cnt     <= '0;
      cpu_cnt       <= '0;
    end else begin
      prev_state    <= power_state;
      shut_prev     <= shutdown_req;
      timer_count   <= timer_next;
      shutdown_cmd  <= shut_rise;
      timer_expired <= expire_c && !shut_rise;
      wakeup_event  <= (expire_c || wake_accept) && !shut_rise;
      radio_request <= enter_active && !shut_rise;
      cpu_cnt       <= cpu_cnt_next;
      cpu_idle      <= is_active && !cpu_busy && (cpu_cnt_next >= thr);
      radio_idle    <= 1'b0;
      // Radio monitor: armed by the request pulse, disarmed on idle or on leaving ACTIVE.
      if (enter_active && !shut_rise) begin
        armed     <= 1'b1;
        radio_cnt <= '0;
      end else if (armed && is_active) begin
        if (radio_busy) begin
          radio_cnt <= '0;
        end else if (radio_inc >= thr) begin
          radio_idle <= 1'b1;
          armed      <= 1'b0;
          radio_cnt  <= '0;
        end else begin
          radio_cnt <= radio_inc;
        end
      end else begin
        armed     <= 1'b0;
        radio_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_power_event_gen.sv
// Scoreboard bench for power_event_gen: a cycle model pushes the expected output word per drive.
module tb_power_event_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  power_state;
  logic [15:0] conn_interval;
  logic [7:0]  idle_threshold;
  logic        ext_wake, shutdown_req, cpu_busy, radio_busy;
  logic        wakeup_event, radio_request, radio_idle, cpu_idle, timer_expired, shutdown_cmd;
  logic [15:0] timer_count;

  always #5 clk = ~clk;

  power_event_gen dut (
    .clk(clk), .reset(reset), .power_state(power_state), .conn_interval(conn_interval),
    .idle_threshold(idle_threshold), .ext_wake(ext_wake), .shutdown_req(shutdown_req),
    .cpu_busy(cpu_busy), .radio_busy(radio_busy), .wakeup_event(wakeup_event),
    .radio_request(radio_request), .radio_idle(radio_idle), .cpu_idle(cpu_idle),
    .timer_expired(timer_expired), .shutdown_cmd(shutdown_cmd), .timer_count(timer_count)
  );

  int total = 0;
  int bad = 0;
  logic [21:0] exp_q[$];

  // Model state
  int m_prev_ps, m_timer, m_prev_wake, m_prev_shut, m_run, m_armed, m_rcnt, m_ccnt;
  // Pulses observed from the DUT, per directed window
  int n_wake, n_texp, n_ridle, n_shut, n_rreq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected outputs after the next edge, from the inputs currently applied.
  task automatic model_step(output logic [21:0] v);
    int ps, thr, timer_nx;
    bit sleep, active, srise, load, expire, accept, ereq, ridle, cidle;
    ps = int'(power_state);
    v = '0;
    if (reset) begin
      m_timer = 0; m_prev_ps = ps; m_prev_wake = int'(ext_wake); m_prev_shut = int'(shutdown_req);
      m_run = ext_wake ? 4 : 0; m_armed = 0; m_rcnt = 0; m_ccnt = 0;
      return;
    end
    thr    = (idle_threshold == 0) ? 1 : int'(idle_threshold);
    sleep  = (ps == 1) || (ps == 2);
    active = (ps == 3);
    srise  = shutdown_req && (m_prev_shut == 0);
    load   = sleep && (m_prev_ps == 3);
    expire = sleep && !load && (m_timer == 1);
`ifdef WAKE_DEBOUNCE_EN
    accept = ext_wake && (m_run == 3) && !active;
    m_run  = ext_wake ? ((m_run >= 4) ? 4 : m_run + 1) : 0;
`else
    accept = ext_wake && (m_prev_wake == 0) && !active;
`endif
    if (srise || !sleep) timer_nx = 0;
    else if (load)       timer_nx = int'(conn_interval);
    else                 timer_nx = (m_timer > 0) ? m_timer - 1 : 0;
    ereq  = active && (m_prev_ps != 3) && !srise;
    ridle = 0;
    if (ereq) begin
      m_armed = 1; m_rcnt = 0;
    end else if (m_armed != 0 && active) begin
      if (radio_busy) m_rcnt = 0;
      else if (m_rcnt + 1 >= thr) begin ridle = 1; m_armed = 0; m_rcnt = 0; end
      else m_rcnt++;
    end else begin
      m_armed = 0; m_rcnt = 0;
    end
    if (active && !cpu_busy) m_ccnt = (m_ccnt >= 255) ? 255 : m_ccnt + 1;
    else                     m_ccnt = 0;
    cidle = active && !cpu_busy && (m_ccnt >= thr);
    v = {(expire || accept) && !srise, ereq, ridle, cidle, expire && !srise, srise, 16'(timer_nx)};
    m_timer = timer_nx; m_prev_ps = ps; m_prev_wake = int'(ext_wake); m_prev_shut = int'(shutdown_req);
  endtask

  task automatic tick(input string tag);
    logic [21:0] v, got, want;
    model_step(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    got  = {wakeup_event, radio_request, radio_idle, cpu_idle, timer_expired, shutdown_cmd, timer_count};
    want = exp_q.pop_front();
    check_eq(tag, 32'(got), 32'(want));
    n_wake  += int'(wakeup_event);
    n_texp  += int'(timer_expired);
    n_ridle += int'(radio_idle);
    n_shut  += int'(shutdown_cmd);
    n_rreq  += int'(radio_request);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick($sformatf("%s%0d", tag, i));
  endtask

  task automatic clear_counts();
    n_wake = 0; n_texp = 0; n_ridle = 0; n_shut = 0; n_rreq = 0;
  endtask

  initial begin
    reset = 1'b1; power_state = 2'b11; conn_interval = 16'd5; idle_threshold = 8'd4;
    ext_wake = 1'b0; shutdown_req = 1'b0; cpu_busy = 1'b0; radio_busy = 1'b0;
    clear_counts();
    ticks("rst", 2);
    check_eq("rst_timer", 32'(timer_count), 32'd0);
    reset = 1'b0;
    ticks("act", 6);
    check_eq("cpu_idle_lvl", 32'(cpu_idle), 32'd1);

    // ACTIVE -> SLEEP with a 5-cycle interval
    clear_counts();
    power_state = 2'b10;
    ticks("int", 8);
    check_eq("int_texp_cnt", 32'(n_texp), 32'd1);
    check_eq("int_wake_cnt", 32'(n_wake), 32'd1);

    // Re-enter ACTIVE, then abort a running count by returning to ACTIVE
    clear_counts();
    power_state = 2'b11; tick("ent");
    power_state = 2'b10; ticks("run", 3);
    check_eq("run_timer3", 32'(timer_count), 32'd3);
    power_state = 2'b11; tick("abort");
    check_eq("abort_timer", 32'(timer_count), 32'd0);
    check_eq("abort_texp", 32'(n_texp), 32'd0);
    check_eq("abort_rreq", 32'(radio_request), 32'd1);

    // Radio idle monitor after the request
    clear_counts();
    radio_busy = 1'b1; ticks("rbusy", 3);
    radio_busy = 1'b0; ticks("ridle", 8);
    check_eq("ridle_cnt", 32'(n_ridle), 32'd1);

    // Shutdown rising in the same cycle the timer would expire
    clear_counts();
    conn_interval = 16'd3;
    power_state = 2'b10; ticks("sd", 3);
    shutdown_req = 1'b1; tick("sd_hit");
    check_eq("sd_cmd", 32'(shutdown_cmd), 32'd1);
    ticks("sd_after", 3);
    shutdown_req = 1'b0; tick("sd_low");
    check_eq("sd_cnt", 32'(n_shut), 32'd1);
    check_eq("sd_texp_cnt", 32'(n_texp), 32'd0);
    check_eq("sd_wake_cnt", 32'(n_wake), 32'd0);

    // ext_wake in DEEPSLEEP: short burst, then a 4-cycle hold
    clear_counts();
    conn_interval = 16'd0;
    power_state = 2'b01; tick("ds");
    ext_wake = 1'b1; ticks("w2_", 2);
    ext_wake = 1'b0; ticks("w2lo", 3);
`ifdef WAKE_DEBOUNCE_EN
    check_eq("wake_short", 32'(n_wake), 32'd0);
`else
    check_eq("wake_short", 32'(n_wake), 32'd1);
`endif
    clear_counts();
    ext_wake = 1'b1; ticks("w4_", 4);
    ext_wake = 1'b0; ticks("w4lo", 3);
    check_eq("wake_long", 32'(n_wake), 32'd1);

    // Zero interval from ACTIVE gives no expiry
    clear_counts();
    power_state = 2'b11; ticks("z_act", 2);
    power_state = 2'b10; ticks("z_slp", 4);
    check_eq("zero_texp", 32'(n_texp), 32'd0);

    // Reset in the middle of a count
    conn_interval = 16'd10;
    power_state = 2'b11; ticks("mr_act", 2);
    power_state = 2'b10; ticks("mr_run", 3);
    reset = 1'b1; tick("mr_rst");
    reset = 1'b0; ticks("mr_post", 5);
    check_eq("mr_timer", 32'(timer_count), 32'd0);

    // Random traffic with sticky power states and occasional reset
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) power_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) conn_interval = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) idle_threshold = 8'($urandom_range(0, 5));
      ext_wake     = ($urandom_range(0, 3) == 0);
      shutdown_req = ($urandom_range(0, 9) == 0);
      cpu_busy     = ($urandom_range(0, 3) == 0);
      radio_busy   = ($urandom_range(0, 2) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
